// File: rtl/mem_arbiter.sv
// mem_arbiter: three-port (download, ROM fetch, CPU RAM) arbiter in front of
// a single SDRAM controller request/ack interface.
// Optional feature macro: MEM_ARB_RR_EN -- alternates rom/ram when both wait;
// when undefined, rom always beats ram. Download always has top priority.
module mem_arbiter #(
  parameter int unsigned AW = 20,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ram_rd,
  input  logic          ram_wr,
  input  logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_din,
  output logic [DW-1:0] ram_dout,
  output logic          ram_ready,
  input  logic          rom_rd,
  input  logic [AW-1:0] rom_addr,
  output logic [DW-1:0] rom_dout,
  output logic          rom_ready,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    grant
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_DL   = 2'd1;
  localparam logic [1:0] G_ROM  = 2'd2;
  localparam logic [1:0] G_RAM  = 2'd3;

  logic [0:0]    state_q, state_d;
  logic          gap_q, gap_d;
  logic          dl_pend_q, dl_pend_d;
  logic [AW-1:0] dl_addr_q, dl_addr_d;
  logic [DW-1:0] dl_data_q, dl_data_d;
  logic          rom_pend_q, rom_pend_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          ram_pend_q, ram_pend_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]    grant_q, grant_d;
  logic [DW-1:0] ram_dout_q, ram_dout_d;
  logic [DW-1:0] rom_dout_q, rom_dout_d;
  logic          ram_ready_q, ram_ready_d;
  logic          rom_ready_q, rom_ready_d;
  logic [1:0]    sel;
`ifdef MEM_ARB_RR_EN
  logic          last_rom_q, last_rom_d;
`endif

  // Port selection among pending requests: dl first, then rom/ram.
  always_comb begin
    sel = G_NONE;
    if (dl_pend_q) sel = G_DL;
`ifdef MEM_ARB_RR_EN
    else if (rom_pend_q && ram_pend_q) sel = last_rom_q ? G_RAM : G_ROM;
`endif
    else if (rom_pend_q) sel = G_ROM;
    else if (ram_pend_q) sel = G_RAM;
  end

  // Request capture, IDLE/BUSY sequencing and completion handling.
  always_comb begin
    state_d     = state_q;
    gap_d       = 1'b0;
    dl_pend_d   = dl_pend_q;
    dl_addr_d   = dl_addr_q;
    dl_data_d   = dl_data_q;
    rom_pend_d  = rom_pend_q;
    rom_addr_d  = rom_addr_q;
    ram_pend_d  = ram_pend_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = grant_q;
    ram_dout_d  = ram_dout_q;
    rom_dout_d  = rom_dout_q;
    ram_ready_d = 1'b0;
    rom_ready_d = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_rom_d  = last_rom_q;
`endif

    // A strobe is only taken when its port has nothing pending.
    if (dl_wr && !dl_pend_q) begin
      dl_pend_d = 1'b1;
      dl_addr_d = dl_addr;
      dl_data_d = dl_data;
    end
    if (rom_rd && !rom_pend_q) begin
      rom_pend_d = 1'b1;
      rom_addr_d = rom_addr;
    end
    if ((ram_rd || ram_wr) && !ram_pend_q) begin
      ram_pend_d = 1'b1;
      ram_we_d   = ram_wr;
      ram_addr_d = ram_addr;
      ram_din_d  = ram_din;
    end

    case (state_q)
      IDLE: begin
        // gap_q holds off arbitration for the first idle cycle after a
        // completion so the finishing port can re-strobe and compete.
        if (!gap_q && (sel != G_NONE)) begin
          state_d   = BUSY;
          mem_req_d = 1'b1;
          grant_d   = sel;
          case (sel)
            G_DL: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = dl_addr_q;
              mem_wdata_d = dl_data_q;
            end
            G_ROM: begin
              mem_we_d    = 1'b0;
              mem_addr_d  = rom_addr_q;
              mem_wdata_d = '0;
`ifdef MEM_ARB_RR_EN
              last_rom_d  = 1'b1;
`endif
            end
            default: begin
              mem_we_d    = ram_we_q;
              mem_addr_d  = ram_addr_q;
              mem_wdata_d = ram_din_q;
`ifdef MEM_ARB_RR_EN
              last_rom_d  = 1'b0;
`endif
            end
          endcase
        end
      end
      default: begin
        if (mem_ack) begin
          state_d   = IDLE;
          gap_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          grant_d   = G_NONE;
          case (grant_q)
            G_DL:  dl_pend_d = 1'b0;
            G_ROM: begin
              rom_pend_d  = 1'b0;
              rom_dout_d  = mem_rdata;
              rom_ready_d = 1'b1;
            end
            G_RAM: begin
              ram_pend_d  = 1'b0;
              ram_ready_d = 1'b1;
              if (!ram_we_q) ram_dout_d = mem_rdata;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gap_q       <= 1'b0;
      dl_pend_q   <= 1'b0;
      dl_addr_q   <= '0;
      dl_data_q   <= '0;
      rom_pend_q  <= 1'b0;
      rom_addr_q  <= '0;
      ram_pend_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_q     <= G_NONE;
      ram_dout_q  <= '0;
      rom_dout_q  <= '0;
      ram_ready_q <= 1'b0;
      rom_ready_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_rom_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      dl_pend_q   <= dl_pend_d;
      dl_addr_q   <= dl_addr_d;
      dl_data_q   <= dl_data_d;
      rom_pend_q  <= rom_pend_d;
      rom_addr_q  <= rom_addr_d;
      ram_pend_q  <= ram_pend_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_q     <= grant_d;
      ram_dout_q  <= ram_dout_d;
      rom_dout_q  <= rom_dout_d;
      ram_ready_q <= ram_ready_d;
      rom_ready_q <= rom_ready_d;
`ifdef MEM_ARB_RR_EN
      last_rom_q  <= last_rom_d;
`endif
    end
  end

  assign ram_dout  = ram_dout_q;
  assign ram_ready = ram_ready_q;
  assign rom_dout  = rom_dout_q;
  assign rom_ready = rom_ready_q;
  assign dl_busy   = dl_pend_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default AW=20, DW=8).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ram_rd, ram_wr;
  logic [19:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;
  logic        ram_ready;
  logic        rom_rd;
  logic [19:0] rom_addr;
  logic [7:0]  rom_dout;
  logic        rom_ready;
  logic        dl_wr;
  logic [19:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_busy;
  logic        mem_req, mem_we;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_ready(ram_ready),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_dout(rom_dout), .rom_ready(rom_ready),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SDRAM controller model: wait for mem_req, record it, ack after lat cycles.
  // Returns in the cycle after the ack.
  task automatic serve(input logic [7:0] rdata, input int lat, output logic ok,
                       output logic [1:0] g, output logic we, output logic [19:0] a,
                       output logic [7:0] wd);
    int n;
    n = 0;
    ok = 1'b1;
    g = 2'd0; we = 1'b0; a = '0; wd = '0;
    while (!mem_req && n < 30) begin
      tick();
      n++;
    end
    if (!mem_req) begin
      ok = 1'b0;
    end else begin
      g = grant; we = mem_we; a = mem_addr; wd = mem_wdata;
      repeat (lat) tick();
      mem_ack = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_ack = 1'b0;
      mem_rdata = '0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (grant !== 2'd0) begin failures++; $display("FAIL reset_grant got %0d exp 0", grant); end
    checks++; if (dl_busy !== 1'b0) begin failures++; $display("FAIL reset_dl_busy got %b exp 0", dl_busy); end
    checks++; if ({ram_ready, rom_ready, mem_we} !== 3'b000) begin failures++; $display("FAIL reset_strobes got %b exp 000", {ram_ready, rom_ready, mem_we}); end
    checks++; if ({ram_dout, rom_dout, mem_wdata} !== 24'h0) begin failures++; $display("FAIL reset_data got %h exp 0", {ram_dout, rom_dout, mem_wdata}); end
    checks++; if (mem_addr !== 20'h0) begin failures++; $display("FAIL reset_addr got %h exp 0", mem_addr); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    ram_rd = 1'b1; ram_addr = 20'h01234;
    tick();                                  // cycle 1
    ram_rd = 1'b0; ram_addr = '0;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rd_req_c1 got %b exp 0", mem_req); end
    tick();                                  // cycle 2
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rd_req_c2 got %b exp 1", mem_req); end
    checks++; if ({grant, mem_we} !== 3'b110) begin failures++; $display("FAIL rd_grant_we got %b exp 110", {grant, mem_we}); end
    checks++; if (mem_addr !== 20'h01234) begin failures++; $display("FAIL rd_addr got %h exp 01234", mem_addr); end
    tick(); tick();                          // cycle 4
    checks++; if ({mem_req, grant, mem_addr} !== {1'b1, 2'd3, 20'h01234}) begin failures++; $display("FAIL rd_stable got %h exp %h", {mem_req, grant, mem_addr}, {1'b1, 2'd3, 20'h01234}); end
    tick();                                  // cycle 5: ack
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    checks++; if (ram_ready !== 1'b0) begin failures++; $display("FAIL rd_ready_early got %b exp 0", ram_ready); end
    tick();                                  // cycle 6
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if (ram_ready !== 1'b1) begin failures++; $display("FAIL rd_ready got %b exp 1", ram_ready); end
    checks++; if (ram_dout !== 8'h5A) begin failures++; $display("FAIL rd_dout got %h exp 5a", ram_dout); end
    checks++; if ({mem_req, grant} !== 3'b000) begin failures++; $display("FAIL rd_release got %b exp 000", {mem_req, grant}); end
    tick();
    checks++; if ({ram_ready, ram_dout} !== {1'b0, 8'h5A}) begin failures++; $display("FAIL rd_ready_pulse got %h exp 05a", {ram_ready, ram_dout}); end
  endtask

  task automatic test_priority();
    logic ok, we; logic [1:0] g; logic [19:0] a; logic [7:0] wd;
    dl_wr = 1'b1; dl_addr = 20'h00010; dl_data = 8'h11;
    rom_rd = 1'b1; rom_addr = 20'h00200;
    ram_wr = 1'b1; ram_addr = 20'h03000; ram_din = 8'h33;
    tick();
    dl_wr = 1'b0; rom_rd = 1'b0; ram_wr = 1'b0;
    checks++; if (dl_busy !== 1'b1) begin failures++; $display("FAIL pri_dl_busy got %b exp 1", dl_busy); end
    serve(8'hF0, 2, ok, g, we, a, wd);
    checks++; if ({ok, g, we, a, wd} !== {1'b1, 2'd1, 1'b1, 20'h00010, 8'h11}) begin failures++; $display("FAIL pri_first got %h exp %h", {ok, g, we, a, wd}, {1'b1, 2'd1, 1'b1, 20'h00010, 8'h11}); end
    checks++; if (dl_busy !== 1'b0) begin failures++; $display("FAIL pri_dl_busy_fall got %b exp 0", dl_busy); end
    serve(8'hC3, 1, ok, g, we, a, wd);
    checks++; if ({ok, g, we, a} !== {1'b1, 2'd2, 1'b0, 20'h00200}) begin failures++; $display("FAIL pri_second got %h exp %h", {ok, g, we, a}, {1'b1, 2'd2, 1'b0, 20'h00200}); end
    checks++; if ({rom_ready, rom_dout} !== {1'b1, 8'hC3}) begin failures++; $display("FAIL pri_rom_data got %h exp 1c3", {rom_ready, rom_dout}); end
    serve(8'hE7, 1, ok, g, we, a, wd);
    checks++; if ({ok, g, we, a, wd} !== {1'b1, 2'd3, 1'b1, 20'h03000, 8'h33}) begin failures++; $display("FAIL pri_third got %h exp %h", {ok, g, we, a, wd}, {1'b1, 2'd3, 1'b1, 20'h03000, 8'h33}); end
    checks++; if ({ram_ready, ram_dout} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL pri_ram_wr got %h exp 15a", {ram_ready, ram_dout}); end
  endtask

  task automatic test_rw_same();
    logic ok, we; logic [1:0] g; logic [19:0] a; logic [7:0] wd;
    ram_rd = 1'b1; ram_wr = 1'b1; ram_addr = 20'h0ABCD; ram_din = 8'hA5;
    tick();
    ram_rd = 1'b0; ram_wr = 1'b0;
    serve(8'h12, 1, ok, g, we, a, wd);
    checks++; if ({ok, g, we, a, wd} !== {1'b1, 2'd3, 1'b1, 20'h0ABCD, 8'hA5}) begin failures++; $display("FAIL rw_txn got %h exp %h", {ok, g, we, a, wd}, {1'b1, 2'd3, 1'b1, 20'h0ABCD, 8'hA5}); end
    checks++; if (ram_dout !== 8'h5A) begin failures++; $display("FAIL rw_dout got %h exp 5a", ram_dout); end
    repeat (5) tick();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rw_single got %b exp 0", mem_req); end
  endtask

  task automatic test_back_to_back();
    logic ok, we; logic [1:0] g, exp_g; logic [19:0] a; logic [7:0] wd;
    ram_rd = 1'b1; ram_addr = 20'h00055;
    rom_rd = 1'b1; rom_addr = 20'h00100;
    tick();
    ram_rd = 1'b0; rom_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_g = (i % 2 == 0) ? 2'd2 : 2'd3;
`else
      exp_g = 2'd2;
`endif
      serve(8'(i + 1), 1, ok, g, we, a, wd);
      checks++; if ({ok, g} !== {1'b1, exp_g}) begin failures++; $display("FAIL b2b_grant_%0d got %b exp %b", i, {ok, g}, {1'b1, exp_g}); end
      if (g == 2'd3) begin
        ram_rd = 1'b1;
      end else begin
        checks++; if ({rom_ready, rom_dout} !== {1'b1, 8'(i + 1)}) begin failures++; $display("FAIL b2b_rom_%0d got %h exp %h", i, {rom_ready, rom_dout}, {1'b1, 8'(i + 1)}); end
        rom_rd = 1'b1;
      end
      tick();
      ram_rd = 1'b0; rom_rd = 1'b0;
    end
    serve(8'h99, 1, ok, g, we, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 2'd2, 20'h00100}) begin failures++; $display("FAIL b2b_drain_rom got %h exp %h", {ok, g, a}, {1'b1, 2'd2, 20'h00100}); end
    serve(8'h88, 1, ok, g, we, a, wd);
    checks++; if ({ok, g, we, a} !== {1'b1, 2'd3, 1'b0, 20'h00055}) begin failures++; $display("FAIL b2b_drain_ram got %h exp %h", {ok, g, we, a}, {1'b1, 2'd3, 1'b0, 20'h00055}); end
    checks++; if ({ram_ready, ram_dout, rom_dout} !== {1'b1, 8'h88, 8'h99}) begin failures++; $display("FAIL b2b_douts got %h exp 18899", {ram_ready, ram_dout, rom_dout}); end
    repeat (4) tick();
  endtask

  task automatic test_spurious();
    logic ok, we; logic [1:0] g; logic [19:0] a; logic [7:0] wd;
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if ({mem_req, ram_ready, rom_ready} !== 3'b000) begin failures++; $display("FAIL sp_no_ready got %b exp 000", {mem_req, ram_ready, rom_ready}); end
    checks++; if ({ram_dout, rom_dout} !== 16'h8899) begin failures++; $display("FAIL sp_douts got %h exp 8899", {ram_dout, rom_dout}); end
    ram_rd = 1'b1; ram_addr = 20'h00111;
    tick();
    ram_addr = 20'h00222;                     // second strobe while pending
    tick();
    ram_rd = 1'b0;
    serve(8'h44, 1, ok, g, we, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 2'd3, 20'h00111}) begin failures++; $display("FAIL sp_first_addr got %h exp %h", {ok, g, a}, {1'b1, 2'd3, 20'h00111}); end
    repeat (6) tick();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sp_second_ignored got %b exp 0", mem_req); end
  endtask

  task automatic test_reset_busy();
    int n;
    logic seen_ready;
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    rom_rd = 1'b1; rom_addr = 20'h00ABC;
    tick();
    rom_rd = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin tick(); n++; end
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rb_busy got %b exp 1", mem_req); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    checks++; if ({mem_req, grant} !== 3'b000) begin failures++; $display("FAIL rb_req got %b exp 000", {mem_req, grant}); end
    seen_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ram_ready || rom_ready || mem_req) seen_ready = 1'b1;
      tick();
    end
    checks++; if (seen_ready !== 1'b0) begin failures++; $display("FAIL rb_no_activity got %b exp 0", seen_ready); end
    checks++; if ({ram_dout, rom_dout} !== 16'h0000) begin failures++; $display("FAIL rb_douts got %h exp 0000", {ram_dout, rom_dout}); end
  endtask

  initial begin
    reset_n = 1'b0;
    ram_rd = 1'b0; ram_wr = 1'b0; ram_addr = '0; ram_din = '0;
    rom_rd = 1'b0; rom_addr = '0;
    dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    test_reset();
    test_single_read();
    test_priority();
    test_rw_same();
    test_back_to_back();
    test_spurious();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 20, address width of all ports.
REQ-002 Parameter DW, default 8, data width of all ports.
REQ-003 clk  in  1  system clock (57.272 MHz domain); the block SHALL use this single clock only.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 ram_rd  in  1  CPU RAM read strobe, one cycle.
REQ-006 ram_wr  in  1  CPU RAM write strobe, one cycle.
REQ-007 ram_addr  in  AW  CPU RAM address, sampled with strobe.
REQ-008 ram_din  in  DW  CPU RAM write data, sampled with strobe.
REQ-009 ram_dout  out  DW  CPU RAM read data, held until next RAM read completes.
REQ-010 ram_ready  out  1  one-cycle completion pulse, RAM port.
REQ-011 rom_rd  in  1  ROM/cart fetch strobe; rom_addr  in  AW  fetch address.
REQ-012 rom_dout  out  DW  ROM read data, held; rom_ready  out  1  completion pulse.
REQ-013 dl_wr  in  1  download write strobe; dl_addr  in  AW; dl_data  in  DW.
REQ-014 dl_busy  out  1  high while a download write is pending or in progress.
REQ-015 mem_req  out  1  request to SDRAM controller; mem_we  out  1; mem_addr  out  AW; mem_wdata  out  DW.
REQ-016 mem_rdata  in  DW  read data, valid with mem_ack; mem_ack  in  1  one-cycle completion.
REQ-017 grant  out  2  current owner: 0 none, 1 dl, 2 rom, 3 ram.

Function
REQ-018 Each port SHALL capture its strobe, address and data into a pending register at the sampling edge; pending visible next cycle.
REQ-019 Strobe on a port already pending SHALL be ignored (first request kept).
REQ-020 ram_rd and ram_wr in the same cycle SHALL be captured as a write.
REQ-021 FSM states IDLE, BUSY; IDLE->BUSY when any pending exists; BUSY->IDLE on mem_ack.
REQ-022 In IDLE, selection SHALL be fixed priority dl > rom > ram (see REQ-031 for rom/ram).
REQ-023 Latency: strobe in cycle 0, port idle and no competitor -> mem_req high in cycle 2.
REQ-024 mem_req, mem_we, mem_addr, mem_wdata, grant SHALL remain stable from assertion until the cycle after mem_ack.
REQ-025 mem_ack in cycle k -> mem_req low and grant 0 in cycle k+1; owner pending cleared in k+1; mem_req low at least one cycle between transactions.
REQ-026 Reads: mem_rdata captured at mem_ack into the owner's dout; owner's ready high exactly in cycle k+1.
REQ-027 Writes: owner's ready pulse in k+1 (ram port); dl_busy falls in k+1; no dout change on writes.
REQ-028 mem_ack while IDLE SHALL be ignored; no dout or ready change.
REQ-029 A strobe arriving on the owner port in cycle k+1 SHALL be accepted (pending already cleared).

Reset
REQ-030 reset_n low at a clock edge: FSM IDLE, all pending cleared, mem_req/mem_we/ready/dl_busy 0, grant 0, mem_addr/mem_wdata/ram_dout/rom_dout 0; in-flight transaction abandoned, late mem_ack ignored.

Configuration
REQ-031 Macro MEM_ARB_RR_EN defined: dl stays highest; between rom and ram, the port not granted most recently wins when both pending (last-grant flag reset to ram, so rom wins first). Undefined: rom always beats ram.

Verification
REQ-032 Single RAM read addr 0x01234, controller acks 3 cycles after mem_req with 0x5A -> mem_req cycle 2, ram_ready one cycle after ack, ram_dout 0x5A.
REQ-033 dl_wr, rom_rd, ram_wr strobed same cycle -> grant sequence 1,2,3; dl_busy falls after first ack; mem_we 1,0,1.
REQ-034 rom_rd re-strobed immediately on every rom_ready with ram_rd pending: without MEM_ARB_RR_EN ram never granted in 10 rom transactions; with it grants alternate 2,3,2,3.
REQ-035 ram_rd and ram_wr same cycle, data 0xA5 -> single transaction, mem_we 1, mem_wdata 0xA5.
REQ-036 reset_n low one cycle while BUSY, then mem_ack 0x77 -> mem_req 0 after reset, no ready pulse, douts remain 0.
REQ-037 Spurious mem_ack in IDLE and second ram_rd while pending -> no ready, only first address issued.
